alu_result_stage: RTL and testbench

//  Registered output stage directly downstream of the 32-bit ALU (alu_top slice array).

---
 rtl/alu_result_stage.sv | 168 ++++++++++++++++
 tb/tb_alu_result_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the 32-bit ALU.
// It captures the result, carry-out, overflow and destination of each entry, and
// derives the zero and negative flags when the entry is captured.
// It hands entries to the MEM stage over a valid/ready handshake.
// A two-entry skid buffer (main + skid) keeps full throughput while in_ready_o
// stays registered.
// Optional feature macro: ALU_STICKY_OVF_EN. When defined, the macro adds a
// sticky overflow flag with ports sticky_clr_i / sticky_ovf_o.
`default_nettype none

module alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_result_i,
  input  logic              in_cout_i,
  input  logic              in_ovf_i,
  input  logic [RD_W-1:0]   in_rd_i,
  input  logic              in_wen_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_result_o,
  output logic              out_zero_o,
  output logic              out_neg_o,
  output logic              out_cout_o,
  output logic              out_ovf_o,
  output logic [RD_W-1:0]   out_rd_o,
  output logic              out_wen_o
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic              sticky_clr_i,
  output logic              sticky_ovf_o
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              neg;
    logic              cout;
    logic              ovf;
    logic [RD_W-1:0]   rd;
    logic              wen;
  } entry_t;

  // Occupancy encoded as {main_v, skid_v}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_t;

  // Flags are derived once, at capture, so the output side is pure registers
  function automatic entry_t capture_entry(
    input logic [DATA_W-1:0] result,
    input logic              cout,
    input logic              ovf,
    input logic [RD_W-1:0]   rd,
    input logic              wen
  );
    entry_t e;
    e.result = result;
    e.zero   = ~|result;
    e.neg    = result[DATA_W-1];
    e.cout   = cout;
    e.ovf    = ovf;
    e.rd     = rd;
    e.wen    = wen;
    return e;
  endfunction

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   in_ready_q;
  logic   accept;
  logic   emit;

  assign in_entry = capture_entry(in_result_i, in_cout_i, in_ovf_i, in_rd_i, in_wen_i);

  // A flushed cycle never accepts; an emit in that cycle still completes downstream
  assign accept = in_valid_i & in_ready_q & ~flush_i;
  assign emit   = out_valid_o & out_ready_i;

  // Occupancy FSM with the main/skid entry registers and the registered ready
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush_i) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
    end else begin
      // Ready is high unless the next state holds a skid entry
      in_ready_q <= 1'b1;
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_entry;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_q <= in_entry;
          end else if (accept) begin
            skid_q     <= in_entry;
            state      <= TWO;
            in_ready_q <= 1'b0;
          end else if (emit) begin
            main_q <= '0;
            state  <= EMPTY;
          end
        end
        TWO: begin
          if (emit) begin
            main_q <= skid_q;
            state  <= ONE;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = (state != EMPTY);
  assign out_result_o = main_q.result;
  assign out_zero_o   = main_q.zero;
  assign out_neg_o    = main_q.neg;
  assign out_cout_o   = main_q.cout;
  assign out_ovf_o    = main_q.ovf;
  assign out_rd_o     = main_q.rd;
  assign out_wen_o    = main_q.wen;

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q;

  // Sticky overflow: set by any emitted overflow (set wins over clear), ignores flush
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (emit && main_q.ovf) begin
      sticky_q <= 1'b1;
    end else if (sticky_clr_i) begin
      sticky_q <= 1'b0;
    end
  end

  assign sticky_ovf_o = sticky_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: table-driven, directed and randomized checks of
// alu_result_stage against a queue-based reference model of the stage.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic        in_cout = 1'b0;
  logic        in_ovf = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_wen = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_neg;
  logic        out_cout;
  logic        out_ovf;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        sticky_clr = 1'b0;
  logic        sticky_ovf;

  int checks = 0;
  int errors = 0;

  alu_result_stage #(.DATA_W(32), .RD_W(5)) dut (
    .clk_i(clk),
    .rst_n(rst_n),
    .flush_i(flush),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .in_result_i(in_result),
    .in_cout_i(in_cout),
    .in_ovf_i(in_ovf),
    .in_rd_i(in_rd),
    .in_wen_i(in_wen),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_result_o(out_result),
    .out_zero_o(out_zero),
    .out_neg_o(out_neg),
    .out_cout_o(out_cout),
    .out_ovf_o(out_ovf),
    .out_rd_o(out_rd),
    .out_wen_o(out_wen)
`ifdef ALU_STICKY_OVF_EN
    ,
    .sticky_clr_i(sticky_clr),
    .sticky_ovf_o(sticky_ovf)
`endif
  );

`ifndef ALU_STICKY_OVF_EN
  assign sticky_ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference model: the stage is a FIFO of capacity two
  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic [4:0]  rd;
    logic        wen;
  } ent_t;

  ent_t q[$];
  logic model_ready = 1'b0;
  logic sticky_m = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic [4:0]  rd;
    logic        wen;
    logic        exp_zero;
    logic        exp_neg;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [41:0] got;
    logic [41:0] exp;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(model_ready));
    if (q.size() > 0) begin
      got = {out_result, out_zero, out_neg, out_cout, out_ovf, out_rd, out_wen};
      exp = {q[0].res, (q[0].res == 32'd0), q[0].res[31], q[0].cout, q[0].ovf, q[0].rd, q[0].wen};
      chk("out_data", 64'(got), 64'(exp));
    end
`ifdef ALU_STICKY_OVF_EN
    chk("sticky_ovf", 64'(sticky_ovf), 64'(sticky_m));
`endif
  endtask

  // One clock: model follows the FIFO rules, then the DUT is compared #1 after the edge
  task automatic step();
    logic acc;
    logic emt;
    logic eovf;
    ent_t e;
    acc  = in_valid && model_ready && !flush;
    emt  = (q.size() > 0) && out_ready;
    eovf = 1'b0;
    if (emt) eovf = q[0].ovf;
    e.res  = in_result;
    e.cout = in_cout;
    e.ovf  = in_ovf;
    e.rd   = in_rd;
    e.wen  = in_wen;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (emt) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    model_ready = (q.size() < 2);
    if (eovf) sticky_m = 1'b1;
    else if (sticky_clr) sticky_m = 1'b0;
    #1;
    check_model();
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic c, input logic o,
                       input logic [4:0] d, input logic w);
    in_valid  = v;
    in_result = r;
    in_cout   = c;
    in_ovf    = o;
    in_rd     = d;
    in_wen    = w;
  endtask

  // Asserted just after an edge; checks asynchronous clearing and the ready release
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef ALU_STICKY_OVF_EN
    chk("rst_sticky", 64'(sticky_ovf), 64'd0);
`endif
    q.delete();
    model_ready = 1'b0;
    sticky_m = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_hold_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    chk("rst_release_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{32'd5,         1'b0, 1'b0, 5'd1,  1'b1, 1'b0, 1'b0};
    tbl[1] = '{32'd0,         1'b1, 1'b0, 5'd2,  1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'h8000_0000, 1'b0, 1'b1, 5'd3,  1'b1, 1'b0, 1'b1};
    tbl[3] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{32'h7FFF_FFFF, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0};
    tbl[5] = '{32'h0000_0001, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Streaming 5, 0, 0x80000000 with no bubbles
    out_ready = 1'b1;
    drive(1'b1, 32'd5, 1'b0, 1'b0, 5'd4, 1'b1);
    step();
    chk("stream0_result", 64'(out_result), 64'd5);
    chk("stream0_zero_neg", 64'({out_zero, out_neg}), 64'b00);
    drive(1'b1, 32'd0, 1'b0, 1'b0, 5'd5, 1'b1);
    step();
    chk("stream1_valid", 64'(out_valid), 64'd1);
    chk("stream1_zero_neg", 64'({out_zero, out_neg}), 64'b10);
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 5'd6, 1'b1);
    step();
    chk("stream2_result", 64'(out_result), 64'h8000_0000);
    chk("stream2_zero_neg", 64'({out_zero, out_neg}), 64'b01);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();

    // Table of flag/passthrough vectors, one entry per cycle
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, tbl[i].res, tbl[i].cout, tbl[i].ovf, tbl[i].rd, tbl[i].wen);
      step();
      chk($sformatf("tbl%0d_fields", i),
          64'({out_valid, out_result, out_cout, out_ovf, out_rd, out_wen}),
          64'({1'b1, tbl[i].res, tbl[i].cout, tbl[i].ovf, tbl[i].rd, tbl[i].wen}));
      chk($sformatf("tbl%0d_flags", i), 64'({out_zero, out_neg}),
          64'({tbl[i].exp_zero, tbl[i].exp_neg}));
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();

    // Backpressure: A, B held, then drained in order
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 5'd7, 1'b1);
    step();
    drive(1'b1, 32'hBBBB_0002, 1'b1, 1'b0, 5'd8, 1'b0);
    step();
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_holds_a", 64'(out_result), 64'hAAAA_0001);
    drive(1'b1, 32'hCCCC_0003, 1'b0, 1'b0, 5'd9, 1'b0);
    step();
    chk("bp_still_a", 64'(out_result), 64'hAAAA_0001);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    out_ready = 1'b1;
    step();
    chk("bp_then_b", 64'(out_result), 64'hBBBB_0002);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Flush from TWO with a same-cycle input
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 1'b0, 1'b0, 5'd10, 1'b1);
    step();
    drive(1'b1, 32'h2222_2222, 1'b0, 1'b0, 5'd11, 1'b1);
    step();
    drive(1'b1, 32'h3333_3333, 1'b0, 1'b0, 5'd12, 1'b1);
    flush = 1'b1;
    step();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    chk("flush_input_dropped", 64'(out_valid), 64'd0);

`ifdef ALU_STICKY_OVF_EN
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    drive(1'b1, 32'd9, 1'b0, 1'b1, 5'd1, 1'b1);
    step();
    drive(1'b1, 32'd10, 1'b0, 1'b0, 5'd2, 1'b1);
    step();
    chk("sticky_set", 64'(sticky_ovf), 64'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    chk("sticky_stays", 64'(sticky_ovf), 64'd1);
    sticky_clr = 1'b1;
    step();
    chk("sticky_cleared", 64'(sticky_ovf), 64'd0);
    sticky_clr = 1'b0;
    drive(1'b1, 32'd11, 1'b0, 1'b1, 5'd3, 1'b1);
    step();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    sticky_clr = 1'b1;
    step();
    chk("sticky_set_wins", 64'(sticky_ovf), 64'd1);
    sticky_clr = 1'b0;
`endif

    // Fill both entries, then reset mid-transfer
    out_ready = 1'b0;
    drive(1'b1, 32'h4444_4444, 1'b0, 1'b0, 5'd13, 1'b1);
    step();
    drive(1'b1, 32'h5555_5555, 1'b0, 1'b0, 5'd14, 1'b1);
    step();
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      case ($urandom_range(0, 3))
        0: r = 32'd0;
        1: r = 32'h8000_0000 | $urandom;
        default: r = $urandom;
      endcase
      drive($urandom_range(0, 3) != 0, r, 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      sticky_clr = ($urandom_range(0, 7) == 0);
      step();
    end
    flush = 1'b0;
    sticky_clr = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    out_ready = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
